imem_loader: RTL and testbench

Serial boot loader that fills the instruction memory before the single-cycle core starts fetching. It receives a length-prefixed program image over an 8N1 UART line and assembles the bytes into 32-bit big-endian words. Each word is written through the instruction-memory write port at byte addresses 0, 4, 8, …, matching the PC/fetch addressing. The core is held in reset through `cpu_hold` until the image is complete; instruction fetch is the reader of this interface and the loader is its writer.

---
 rtl/imem_loader.sv | 238 +++++++++++++++++++++++
 tb/tb_imem_loader.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: serial boot loader for the instruction memory.
//
// Receives a length-prefixed program image over an 8N1 UART line. The
// image is a 16-bit big-endian word count N followed by 4*N bytes. The
// bytes are packed big-endian into 32-bit words and written to the
// instruction memory at byte addresses 0, 4, 8, ... The core is held in
// reset through cpu_hold until the image is complete.
//
// Ports:
//   clk           system clock, all logic on posedge
//   rst           asynchronous active-low reset
//   uart_rx       serial input, idle high, 8N1, LSB first, async to clk
//   imem_we       single-cycle instruction-memory write strobe
//   imem_addr     byte address of the write (multiple of 4)
//   imem_wdata    word to write; first received byte in [31:24]
//   cpu_hold      high while loading; drives the core reset
//   done          image completely written (sticky until reset)
//   err           load aborted (sticky until reset)
//   words_loaded  number of words written so far
//   rx_state_dbg  receiver FSM state (debug observation)
//   ld_state_dbg  loader FSM state (debug observation)
//
// Handshake: the receiver hands bytes to the loader with byte_valid, a
// one-cycle strobe with no ready/backpressure; byte_data is valid only in
// that cycle. The loader likewise issues imem_we as a one-cycle strobe
// that the memory must accept unconditionally; imem_addr/imem_wdata are
// meaningful while imem_we is high and hold their value otherwise.
module imem_loader #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned MAX_WORDS    = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rx,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        err,
  output logic [15:0] words_loaded,
  output logic [1:0]  rx_state_dbg,
  output logic [2:0]  ld_state_dbg
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [15:0]   MAX_N   = 16'(MAX_WORDS);

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  typedef enum logic [2:0] {
    LD_HDR_HI = 3'd0,
    LD_HDR_LO = 3'd1,
    LD_DATA   = 3'd2,
    LD_DONE   = 3'd3,
    LD_ERROR  = 3'd4
  } ld_state_t;

  // ---------------------------------------------------------------------
  // Two-flop synchronizer; resets to the idle line level so that reset
  // release never looks like a start bit.
  // ---------------------------------------------------------------------
  logic rx_meta;
  logic rx_sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
    end
  end

  // ---------------------------------------------------------------------
  // UART receiver
  // ---------------------------------------------------------------------
  rx_state_t       rx_state;
  logic [CW-1:0]   bit_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      rx_shift;
  logic            byte_valid;
  logic [7:0]      byte_data;
  logic            frame_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state   <= RX_IDLE;
      bit_cnt    <= '0;
      bit_idx    <= '0;
      rx_shift   <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          bit_cnt <= '0;
          bit_idx <= '0;
          if (!rx_sync) rx_state <= RX_START;
        end
        RX_START: begin
          // Re-check the line half a bit later; a high level here means
          // the falling edge was a glitch and is silently dropped.
          if (bit_cnt == HALF_M1) begin
            bit_cnt  <= '0;
            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (bit_cnt == BIT_M1) begin
            bit_cnt  <= '0;
            rx_shift <= {rx_sync, rx_shift[7:1]};
            bit_idx  <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) rx_state <= RX_STOP;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (bit_cnt == BIT_M1) begin
            bit_cnt    <= '0;
            byte_valid <= rx_sync;
            frame_err  <= ~rx_sync;
            byte_data  <= rx_shift;
            rx_state   <= RX_IDLE;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Loader
  // ---------------------------------------------------------------------
  ld_state_t   ld_state;
  logic [7:0]  n_hi;
  logic [15:0] n_words;
  logic [23:0] asm_reg;   // first three bytes of the word in progress
  logic [1:0]  byte_cnt;
  logic [15:0] hdr_n;
  logic [15:0] next_count;

  assign hdr_n      = {n_hi, byte_data};
  assign next_count = words_loaded + 16'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_state     <= LD_HDR_HI;
      n_hi         <= '0;
      n_words      <= '0;
      asm_reg      <= '0;
      byte_cnt     <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      cpu_hold     <= 1'b1;
      done         <= 1'b0;
      err          <= 1'b0;
      words_loaded <= '0;
    end else begin
      imem_we <= 1'b0;
      case (ld_state)
        LD_HDR_HI: begin
          if (frame_err) begin
            ld_state <= LD_ERROR;
            err      <= 1'b1;
          end else if (byte_valid) begin
            n_hi     <= byte_data;
            ld_state <= LD_HDR_LO;
          end
        end
        LD_HDR_LO: begin
          if (frame_err) begin
            ld_state <= LD_ERROR;
            err      <= 1'b1;
          end else if (byte_valid) begin
            n_words <= hdr_n;
            if (hdr_n == 16'd0) begin
              ld_state <= LD_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else if (hdr_n > MAX_N) begin
              ld_state <= LD_ERROR;
              err      <= 1'b1;
            end else begin
              ld_state <= LD_DATA;
            end
          end
        end
        LD_DATA: begin
          if (frame_err) begin
            // Any partially assembled word is simply abandoned.
            ld_state <= LD_ERROR;
            err      <= 1'b1;
          end else if (byte_valid) begin
            asm_reg  <= {asm_reg[15:0], byte_data};
            byte_cnt <= byte_cnt + 1'b1;
            if (byte_cnt == 2'd3) begin
              imem_we      <= 1'b1;
              imem_wdata   <= {asm_reg, byte_data};
              imem_addr    <= {14'b0, words_loaded, 2'b00};
              words_loaded <= next_count;
              // Release the core on the same edge as the final write.
              if (next_count == n_words) begin
                ld_state <= LD_DONE;
                done     <= 1'b1;
                cpu_hold <= 1'b0;
              end
            end
          end
        end
        LD_DONE:  ld_state <= LD_DONE;
        LD_ERROR: ld_state <= LD_ERROR;
        default:  ld_state <= LD_ERROR;
      endcase
    end
  end

  assign rx_state_dbg = rx_state;
  assign ld_state_dbg = ld_state;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader with CLKS_PER_BIT=16, MAX_WORDS=8.
module tb_imem_loader;

  localparam int CPB  = 16;
  localparam int MAXW = 8;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic uart_rx = 1'b1;

  always #5 clk = ~clk;

  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        err;
  logic [15:0] words_loaded;
  logic [1:0]  rx_state_dbg;
  logic [2:0]  ld_state_dbg;

  imem_loader #(.CLKS_PER_BIT(CPB), .MAX_WORDS(MAXW)) dut (
    .clk          (clk),
    .rst          (rst),
    .uart_rx      (uart_rx),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded),
    .rx_state_dbg (rx_state_dbg),
    .ld_state_dbg (ld_state_dbg)
  );

  int tests = 0;
  int fails = 0;

  // Expected writes: {done_expected, addr, data}
  logic [64:0] exp_q[$];
  logic [64:0] mon_e;
  logic        prev_we = 1'b0;
  logic [7:0]  seq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every write strobe is popped and compared.
  always @(negedge clk) begin
    if (rst && imem_we) begin
      check("we_one_cycle", {31'b0, prev_we}, 32'd0);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write",
                 imem_addr, imem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", imem_addr, mon_e[63:32]);
        check("wr_data", imem_wdata, mon_e[31:0]);
        check("wr_done", {31'b0, done}, {31'b0, mon_e[64]});
        check("wr_cpu_hold", {31'b0, cpu_hold}, {31'b0, ~mon_e[64]});
      end
    end
    prev_we = imem_we;
  end

  // Driver tasks (all start and end on a negedge)
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop_bit;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
  endtask

  task automatic send_seq();
    for (int i = 0; i < seq.size(); i++) send_byte(seq[i], 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_we"},    {31'b0, imem_we}, 32'd0);
    check({tag, "_addr"},  imem_addr, 32'd0);
    check({tag, "_wdata"}, imem_wdata, 32'd0);
    check({tag, "_hold"},  {31'b0, cpu_hold}, 32'd1);
    check({tag, "_done"},  {31'b0, done}, 32'd0);
    check({tag, "_err"},   {31'b0, err}, 32'd0);
    check({tag, "_words"}, {16'b0, words_loaded}, 32'd0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b0;
    uart_rx = 1'b1;
    #1;
    check_reset_vals(tag);
    idle(3);
    rst = 1'b1;
    idle(3);
  endtask

  task automatic check_status(input string tag, input logic e_done, input logic e_err,
                              input logic [15:0] e_words);
    check({tag, "_done"},  {31'b0, done}, {31'b0, e_done});
    check({tag, "_hold"},  {31'b0, cpu_hold}, {31'b0, ~e_done});
    check({tag, "_err"},   {31'b0, err}, {31'b0, e_err});
    check({tag, "_words"}, {16'b0, words_loaded}, {16'b0, e_words});
    check({tag, "_pending"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    @(negedge clk);

    // Two-word image
    do_reset("rst1");
    exp_q.push_back({1'b0, 32'h0000_0000, 32'h1234_5678});
    exp_q.push_back({1'b1, 32'h0000_0004, 32'h9ABC_DEF0});
    seq = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    send_seq();
    idle(4);
    check_status("two_words", 1'b1, 1'b0, 16'd2);

    // Empty image, trailing bytes ignored
    do_reset("rst2");
    seq = '{8'h00, 8'h00};
    send_seq();
    idle(4);
    check_status("empty", 1'b1, 1'b0, 16'd0);
    seq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_seq();
    idle(4);
    check_status("empty_tail", 1'b1, 1'b0, 16'd0);

    // Oversized header
    do_reset("rst3");
    seq = '{8'h00, 8'h09};
    send_seq();
    idle(4);
    check_status("too_big", 1'b0, 1'b1, 16'd0);
    for (int i = 0; i < 36; i++) send_byte(8'(i * 7 + 1), 1'b1);
    idle(4);
    check_status("too_big_tail", 1'b0, 1'b1, 16'd0);

    // Framing error mid-word
    do_reset("rst4");
    seq = '{8'h00, 8'h01, 8'h11, 8'h22};
    send_seq();
    send_byte(8'h33, 1'b0);
    idle(3 * CPB);
    check_status("framing", 1'b0, 1'b1, 16'd0);

    // Glitch rejection then a valid image
    do_reset("rst5");
    uart_rx = 1'b0;
    idle(3);
    uart_rx = 1'b1;
    idle(2 * CPB);
    check("glitch_rx_idle", {30'b0, rx_state_dbg}, 32'd0);
    check("glitch_err", {31'b0, err}, 32'd0);
    check("glitch_hold", {31'b0, cpu_hold}, 32'd1);
    exp_q.push_back({1'b1, 32'h0000_0000, 32'hDEAD_BEEF});
    seq = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_seq();
    idle(4);
    check_status("after_glitch", 1'b1, 1'b0, 16'd1);

    // Reset mid-load (mid-word and mid-frame)
    do_reset("rst6");
    exp_q.push_back({1'b0, 32'h0000_0000, 32'h1234_5678});
    seq = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'hAB};
    send_seq();
    check_status("pre_reset", 1'b0, 1'b0, 16'd1);
    uart_rx = 1'b0;
    idle(5);
    do_reset("mid_reset");
    exp_q.push_back({1'b1, 32'h0000_0000, 32'hCAFE_BABE});
    seq = '{8'h00, 8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE};
    send_seq();
    idle(4);
    check_status("reload", 1'b1, 1'b0, 16'd1);
    check("reload_addr", imem_addr, 32'h0000_0000);
    check("reload_data", imem_wdata, 32'hCAFE_BABE);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
